fetch_unit: RTL and testbench

Instruction fetch stage for the 16-bit single-issue CPU, sitting directly upstream of decode/execute. Holds the PC and issues word reads to instruction memory over a request/response handshake that tolerates variable latency. Buffers returned instructions with their PCs in a small prefetch queue and presents them to decode over a valid/ready interface. Branch and jump redirects flush the queue and steer fetch to the new target.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 52 +++++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, halt opcode, PC step and fetch FSM states.
package cpu_pkg;
  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam logic [3:0]        OPCODE_HLT = 4'hF;
  localparam logic [ADDR_W-1:0] PC_INC     = 16'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HALTED
  } fetch_state_e;

  function automatic logic is_hlt_op(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: 4] == OPCODE_HLT;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, instr}; flush and reset both empty it.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ADDR_W + INSTR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = count_q == (PW+1)'(DEPTH);
  assign empty   = count_q == '0;
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, prefetch queue, redirect.
// Halt predecode is built only when FETCH_HLT_DETECT_EN is defined.
//
// state     | meaning
// ST_IDLE   | no live request; issues when a queue slot is free (waits out a stale response if drop_q)
// ST_WAIT   | one request outstanding; imem_req/imem_addr held
// ST_HALTED | halt opcode fetched; no more requests, queue still drains
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               dec_valid,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc,
  input  logic               dec_ready,
  output logic               hlt
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e              state_q;
  logic [ADDR_W-1:0]         pc_q, addr_q;
  logic                      drop_q;
  logic                      outstanding, redir_eff, resp_ok, hlt_hit;
  logic                      fifo_push, fifo_full, fifo_empty;
  logic [CNT_W-1:0]          fifo_count;
  logic [ADDR_W-1:0]         tgt_pc;
  logic [ADDR_W+INSTR_W-1:0] fifo_rdata;

`ifdef FETCH_HLT_DETECT_EN
  assign hlt_hit = is_hlt_op(imem_rdata);
  assign hlt     = state_q == ST_HALTED;
`else
  assign hlt_hit = 1'b0;
  assign hlt     = 1'b0;
`endif

  // A response is still owed to us in WAIT, or in IDLE after a reset/redirect abandoned one.
  assign outstanding = (state_q == ST_WAIT) || drop_q;
  assign redir_eff   = redirect && (state_q != ST_HALTED);
  assign resp_ok     = (state_q == ST_WAIT) && imem_valid && !drop_q;
  assign fifo_push   = resp_ok && !redir_eff && !fifo_full;
  assign tgt_pc      = {redirect_pc[ADDR_W-1:1], 1'b0};
  assign imem_req    = state_q == ST_WAIT;
  assign imem_addr   = addr_q;
  assign dec_valid   = !fifo_empty;
  assign {dec_pc, dec_instr} = fifo_rdata;

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(ADDR_W + INSTR_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redir_eff),
    .push  (fifo_push),
    .pop   (dec_ready),
    .wdata ({addr_q, imem_rdata}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      drop_q  <= outstanding && !imem_valid;
    end else if (redir_eff) begin
      pc_q <= tgt_pc;
      if (outstanding && !imem_valid) begin
        drop_q <= 1'b1;
      end else begin
        drop_q  <= 1'b0;
        state_q <= ST_WAIT;
        addr_q  <= tgt_pc;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (drop_q) begin
            if (imem_valid) drop_q <= 1'b0;
          end else if (fifo_count < CNT_W'(DEPTH)) begin
            state_q <= ST_WAIT;
            addr_q  <= pc_q;
          end
        end
        ST_WAIT: begin
          if (imem_valid) begin
            drop_q <= 1'b0;
            if (drop_q) begin
              state_q <= ST_IDLE;
            end else begin
              pc_q    <= addr_q + PC_INC;
              state_q <= hlt_hit ? ST_HALTED : ST_IDLE;
            end
          end
        end
        ST_HALTED: state_q <= ST_HALTED;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency instruction memory responder.
module tb_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        dec_valid;
  logic [15:0] dec_instr;
  logic [15:0] dec_pc;
  logic        dec_ready = 1'b0;
  logic        hlt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int          mem_lat = 1;
  logic        hlt_en = 1'b0;
  logic [15:0] hlt_addr = 16'h0004;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [15:0] paddr = '0;

  logic [15:0] req_log[$];
  int          req_cyc[$];
  logic [15:0] got_pc[$];
  logic [15:0] got_instr[$];

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dec_valid   (dec_valid),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .dec_ready   (dec_ready),
    .hlt         (hlt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (hlt_en && a == hlt_addr) return 16'hF000;
    return 16'h1234 + a;
  endfunction

  always @(posedge clk) cyc++;

  // Memory responds mem_lat cycles after accepting a request, even if the request is abandoned.
  always @(negedge clk) begin
    imem_valid = 1'b0;
    if (!pend && imem_req) begin
      pend  = 1'b1;
      cnt   = mem_lat;
      paddr = imem_addr;
      req_log.push_back(imem_addr);
      req_cyc.push_back(cyc);
    end
    if (pend) begin
      if (cnt <= 1) begin
        imem_valid = 1'b1;
        imem_rdata = mem_word(paddr);
        pend       = 1'b0;
      end else begin
        cnt--;
      end
    end
    if (!rst && !redirect && dec_valid && dec_ready) begin
      got_pc.push_back(dec_pc);
      got_instr.push_back(dec_instr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    req_log.delete();
    req_cyc.delete();
    got_pc.delete();
    got_instr.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    repeat (6) tick();
    clear_logs();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    mem_lat = 1;
    dec_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL rst_dec_valid got=%b exp=0", dec_valid); end
    checks++; if (hlt !== 1'b0) begin failures++; $display("FAIL rst_hlt got=%b exp=0", hlt); end
    clear_logs();
    rst = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== RESET_PC) begin failures++; $display("FAIL first_addr got=%h exp=%h", imem_addr, RESET_PC); end
    tick();
    checks++; if (dec_valid !== 1'b1) begin failures++; $display("FAIL first_dec_valid got=%b exp=1", dec_valid); end
    checks++; if (dec_instr !== 16'h1234) begin failures++; $display("FAIL first_instr got=%h exp=1234", dec_instr); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL idle_after_resp got=%b exp=0", imem_req); end
  endtask

  task automatic test_stream();
    do_reset();
    mem_lat = 1;
    dec_ready = 1'b1;
    repeat (10) tick();
    for (int i = 0; i < 3; i++) begin
      logic [15:0] epc;
      epc = 16'(2 * i);
      checks++; if (got_pc[i] !== epc) begin failures++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, got_pc[i], epc); end
      checks++; if (got_instr[i] !== 16'h1234 + epc) begin failures++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, got_instr[i], 16'h1234 + epc); end
    end
    checks++; if (req_cyc[1] - req_cyc[0] !== 2) begin failures++; $display("FAIL stream_rate01 got=%0d exp=2", req_cyc[1] - req_cyc[0]); end
    checks++; if (req_cyc[2] - req_cyc[1] !== 2) begin failures++; $display("FAIL stream_rate12 got=%0d exp=2", req_cyc[2] - req_cyc[1]); end
  endtask

  task automatic test_backpressure();
    do_reset();
    mem_lat = 1;
    dec_ready = 1'b0;
    repeat (20) tick();
    checks++; if (req_log.size() !== 4) begin failures++; $display("FAIL bp_req_count got=%0d exp=4", req_log.size()); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_gated got=%b exp=0", imem_req); end
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 16'h0000) begin failures++; $display("FAIL bp_head got=%b/%h exp=1/0000", dec_valid, dec_pc); end
    dec_ready = 1'b1;
    repeat (12) tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_pc[i] !== 16'(2 * i)) begin failures++; $display("FAIL bp_drain[%0d] got=%h exp=%h", i, got_pc[i], 16'(2 * i)); end
    end
    checks++; if (req_log[4] !== 16'h0008) begin failures++; $display("FAIL bp_resume got=%h exp=0008", req_log[4]); end
  endtask

  task automatic test_redirect();
    bit ok;
    do_reset();
    mem_lat = 3;
    dec_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (imem_req && imem_addr == 16'h0006) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL redir_wait6 got=timeout exp=req_at_0006"); end
    redirect = 1'b1;
    redirect_pc = 16'h0101;
    got_pc.delete();
    got_instr.delete();
    tick();
    redirect = 1'b0;
    req_log.delete();
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got=%b exp=0", dec_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0006) begin failures++; $display("FAIL redir_hold got=%b/%h exp=1/0006", imem_req, imem_addr); end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (got_pc.size() > 0) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL redir_wait_entry got=timeout exp=entry"); end
    checks++; if (got_pc[0] !== 16'h0100) begin failures++; $display("FAIL redir_pc got=%h exp=0100", got_pc[0]); end
    checks++; if (got_instr[0] !== 16'h1334) begin failures++; $display("FAIL redir_instr got=%h exp=1334", got_instr[0]); end
    checks++; if (req_log[0] !== 16'h0100) begin failures++; $display("FAIL redir_req got=%h exp=0100", req_log[0]); end
    mem_lat = 1;
  endtask

  task automatic test_halt();
    do_reset();
    mem_lat = 1;
    hlt_en = 1'b1;
    dec_ready = 1'b0;
    repeat (16) tick();
`ifdef FETCH_HLT_DETECT_EN
    checks++; if (hlt !== 1'b1) begin failures++; $display("FAIL halt_flag got=%b exp=1", hlt); end
    checks++; if (req_log.size() !== 3 || imem_req !== 1'b0) begin failures++; $display("FAIL halt_no_req got=%0d/%b exp=3/0", req_log.size(), imem_req); end
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    checks++; if (hlt !== 1'b1 || dec_valid !== 1'b1 || dec_pc !== 16'h0000) begin failures++; $display("FAIL halt_redir_ignored got=%b/%b/%h exp=1/1/0000", hlt, dec_valid, dec_pc); end
    dec_ready = 1'b1;
    repeat (8) tick();
    checks++; if (got_pc.size() !== 3) begin failures++; $display("FAIL halt_drain_count got=%0d exp=3", got_pc.size()); end
    checks++; if (got_pc[2] !== 16'h0004 || got_instr[2] !== 16'hF000) begin failures++; $display("FAIL halt_entry got=%h/%h exp=0004/f000", got_pc[2], got_instr[2]); end
    checks++; if (req_log.size() !== 3) begin failures++; $display("FAIL halt_stays got=%0d exp=3", req_log.size()); end
`else
    checks++; if (hlt !== 1'b0) begin failures++; $display("FAIL nohalt_flag got=%b exp=0", hlt); end
    checks++; if (req_log[3] !== 16'h0006) begin failures++; $display("FAIL nohalt_continue got=%h exp=0006", req_log[3]); end
    dec_ready = 1'b1;
    repeat (8) tick();
    checks++; if (got_pc[2] !== 16'h0004 || got_instr[2] !== 16'hF000) begin failures++; $display("FAIL nohalt_entry got=%h/%h exp=0004/f000", got_pc[2], got_instr[2]); end
    checks++; if (got_pc[3] !== 16'h0006) begin failures++; $display("FAIL nohalt_next got=%h exp=0006", got_pc[3]); end
`endif
    hlt_en = 1'b0;
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    repeat (6) tick();
    clear_logs();
    mem_lat = 1;
    dec_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 16'hFFFE;
    rst = 1'b0;
    tick();
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'hFFFE) begin failures++; $display("FAIL wrap_issue got=%b/%h exp=1/fffe", imem_req, imem_addr); end
    repeat (8) tick();
    checks++; if (req_log[1] !== 16'h0000) begin failures++; $display("FAIL wrap_next_req got=%h exp=0000", req_log[1]); end
    checks++; if (got_pc[0] !== 16'hFFFE || got_instr[0] !== 16'h1232) begin failures++; $display("FAIL wrap_entry0 got=%h/%h exp=fffe/1232", got_pc[0], got_instr[0]); end
    checks++; if (got_pc[1] !== 16'h0000) begin failures++; $display("FAIL wrap_entry1 got=%h exp=0000", got_pc[1]); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    do_reset();
    mem_lat = 4;
    dec_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (imem_req && imem_addr == 16'h0002) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL rstw_wait2 got=timeout exp=req_at_0002"); end
    rst = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b0 || dec_valid !== 1'b0) begin failures++; $display("FAIL rstw_abandon got=%b/%b exp=0/0", imem_req, dec_valid); end
    clear_logs();
    rst = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rstw_hold_off got=%b exp=0", imem_req); end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (got_pc.size() > 0) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL rstw_wait_entry got=timeout exp=entry"); end
    checks++; if (got_pc[0] !== RESET_PC || got_instr[0] !== 16'h1234) begin failures++; $display("FAIL rstw_first got=%h/%h exp=%h/1234", got_pc[0], got_instr[0], RESET_PC); end
    checks++; if (req_log[0] !== RESET_PC) begin failures++; $display("FAIL rstw_req got=%h exp=%h", req_log[0], RESET_PC); end
    mem_lat = 1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
